// File: rtl/regfile_pkg.sv
// Shared helpers and types for the multi-ported register file.
package regfile_pkg;

    localparam int MAX_NWRITE = 2;
    localparam int MAX_DEPTH  = 64;

    // Sized for the largest supported DEPTH; users read only the low DEPTH bits.
    typedef logic [MAX_DEPTH-1:0] wr_onehot_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_wr_decode.sv
// Per-register write enable and source-port select, with highest-port-wins merge and r0 masking.
// Purely combinational; no backpressure.
module regfile_wr_decode
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int NWRITE   = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [NWRITE-1:0]                           wr_en,
    input  logic [NWRITE-1:0][addr_w(DEPTH)-1:0]        wr_addr,
    output logic [DEPTH-1:0]                            reg_we,
    output logic [DEPTH-1:0][$clog2(MAX_NWRITE)-1:0]    reg_sel
);

    localparam int SELW = $clog2(MAX_NWRITE);

    wr_onehot_t oh;
    wr_onehot_t oh_any;
    logic       unused_oh;

    always_comb begin
        reg_we = '0;
        reg_sel = '0;
        oh = '0;
        oh_any = '0;
        // Ascending port order lets the highest-indexed port overwrite the select.
        for (int p = 0; p < NWRITE; p++) begin
            oh = '0;
            if (wr_en[p]) oh[wr_addr[p]] = 1'b1;
            oh_any = oh_any | oh;
            for (int r = 0; r < DEPTH; r++) begin
                if (oh[r]) begin
                    reg_we[r]  = 1'b1;
                    reg_sel[r] = SELW'(p);
                end
            end
        end
        if (ZERO_REG) reg_we[0] = 1'b0;
    end

    assign unused_oh = ^oh_any;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with pending scoreboard; combinational reads, 1-cycle writes, no backpressure.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 32,
    parameter int               NREAD       = 2,
    parameter int               NWRITE      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ZERO_REG    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NREAD-1:0][addr_w(DEPTH)-1:0]  rd_addr,
    output logic [NREAD-1:0][WIDTH-1:0]          rd_data,
    output logic [NREAD-1:0]                     rd_pending,
    input  logic [NWRITE-1:0]                    wr_en,
    input  logic [NWRITE-1:0][addr_w(DEPTH)-1:0] wr_addr,
    input  logic [NWRITE-1:0][WIDTH-1:0]         wr_data,
    input  logic                                 iss_en,
    input  logic [addr_w(DEPTH)-1:0]             iss_addr
);

    localparam int AW   = addr_w(DEPTH);
    localparam int SELW = $clog2(MAX_NWRITE);

    logic [WIDTH-1:0]                mem [DEPTH];
    logic [DEPTH-1:0]                pend;
    logic [DEPTH-1:0]                reg_we;
    logic [DEPTH-1:0][SELW-1:0]      reg_sel;

    regfile_wr_decode #(
        .DEPTH    (DEPTH),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_wr_decode (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .reg_we  (reg_we),
        .reg_sel (reg_sel)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= RESET_VALUE;
            pend <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (reg_we[r]) begin
                    mem[r]  <= wr_data[reg_sel[r]];
                    pend[r] <= 1'b0;
                end
                // Issue is assigned last so a new producer beats a retiring write.
                if (iss_en && iss_addr == AW'(r) && !(ZERO_REG && r == 0))
                    pend[r] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i]    = mem[rd_addr[i]];
            rd_pending[i] = pend[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            if (reg_we[rd_addr[i]]) begin
                rd_data[i]    = wr_data[reg_sel[rd_addr[i]]];
                rd_pending[i] = iss_en && (iss_addr == rd_addr[i]);
            end
`endif
            if (ZERO_REG && rd_addr[i] == '0) begin
                rd_data[i]    = '0;
                rd_pending[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp with a behavioural array model.
module tb_regfile_mp;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 32;
    localparam int          NREAD  = 2;
    localparam int          NWRITE = 2;
    localparam logic [31:0] RV     = 32'h5A;
    localparam bit          ZR     = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NREAD-1:0][4:0]   rd_addr = '0;
    logic [NREAD-1:0][31:0]  rd_data;
    logic [NREAD-1:0]        rd_pending;
    logic [NWRITE-1:0]       wr_en = '0;
    logic [NWRITE-1:0][4:0]  wr_addr = '0;
    logic [NWRITE-1:0][31:0] wr_data = '0;
    logic                    iss_en = 1'b0;
    logic [4:0]              iss_addr = '0;

    regfile_mp #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE),
        .RESET_VALUE(RV), .ZERO_REG(ZR)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREAD-1:0][4:0]  a;
        logic [NREAD-1:0][31:0] d;
        logic [NREAD-1:0]       p;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_reg  [DEPTH];
    bit          m_pend [DEPTH];
    int          checks = 0;
    int          errors = 0;

    // Applies one cycle of stimulus, queues the expected read response, then advances the model.
    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        exp_t        e;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        wr_en = we; wr_addr[0] = wa0; wr_addr[1] = wa1; wr_data[0] = wd0; wr_data[1] = wd1;
        iss_en = ie; iss_addr = ia; rd_addr[0] = ra0; rd_addr[1] = ra1;
        e = '0;
        for (int i = 0; i < NREAD; i++) begin
            e.a[i] = ra[i];
            e.d[i] = m_reg[ra[i]];
            e.p[i] = m_pend[ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWRITE; p++) begin
                if (we[p] && wa[p] == ra[i]) begin
                    e.d[i] = wd[p];
                    e.p[i] = ie && (ia == ra[i]);
                end
            end
`endif
            if (ZR && ra[i] == 5'd0) begin
                e.d[i] = 32'd0;
                e.p[i] = 1'b0;
            end
        end
        sb_q.push_back(e);
        for (int p = 0; p < NWRITE; p++) begin
            if (we[p] && !(ZR && wa[p] == 5'd0)) begin
                m_reg[wa[p]]  = wd[p];
                m_pend[wa[p]] = 1'b0;
            end
        end
        if (ie && !(ZR && ia == 5'd0)) m_pend[ia] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < NREAD; i++) begin
                checks++;
                if (rd_data[i] !== e.d[i]) begin
                    errors++;
                    $display("FAIL rd_data port%0d addr=%0d got=%h exp=%h", i, e.a[i], rd_data[i], e.d[i]);
                end
                checks++;
                if (rd_pending[i] !== e.p[i]) begin
                    errors++;
                    $display("FAIL rd_pending port%0d addr=%0d got=%b exp=%b", i, e.a[i], rd_pending[i], e.p[i]);
                end
            end
        end
    end

    initial begin
        // Reset held for two edges with every write port and issue active.
        reset = 1'b0;
        wr_en = 2'b11; wr_addr[0] = 5'd4; wr_addr[1] = 5'd0;
        wr_data[0] = 32'h1111_1111; wr_data[1] = 32'h2222_2222;
        iss_en = 1'b1; iss_addr = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < DEPTH; r++) begin
            m_reg[r]  = RV;
            m_pend[r] = 1'b0;
        end
        reset = 1'b1;

        for (int a = 0; a < DEPTH; a += 2)
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(a + 1));

        drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0, 5'd0, 5'd6, 5'd6);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd5);

        drive(2'b11, 5'd7, 5'd7, 32'd1, 32'd2, 1'b0, 5'd0, 5'd7, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);

        drive(2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd2);
        drive(2'b01, 5'd3, 5'd0, 32'h33, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        drive(2'b10, 5'd0, 5'd3, 32'd0, 32'h44, 1'b0, 5'd0, 5'd3, 5'd3);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);

        drive(2'b01, 5'd9, 5'd0, 32'h1234, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            drive(2'($urandom), 5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
                  $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, hi)),
                  5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)));
        end

        wr_en = '0; iss_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
